// File: rtl/fifo_ctrl_16x8_pkg.sv
// Shared types and default sizes for the 16x8 FIFO sequencer.
package fifo_ctrl_16x8_pkg;

  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned ADDR_W_DEF = 4;
  localparam int unsigned DEPTH_DEF  = 16;

  // The state bit doubles as rd_valid, which is why ST_HEAD is 1.
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_HEAD  = 1'b1
  } state_t;

endpackage

// File: rtl/fifo_ctrl_16x8_ptr.sv
// Wrapping array pointer with increment and synchronous clear.
module fifo_ctrl_16x8_ptr #(
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              inc,
  output logic [ADDR_W-1:0] ptr
);

  // Natural overflow gives the mod-DEPTH wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (clr) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= ptr + ADDR_W'(1);
    end
  end

endmodule

// File: rtl/fifo_ctrl_16x8.sv
// First-word-fall-through sequencer for a 16x8 sync-write / registered-read array.
// Optional FIFO_CTRL_LEVEL_EN adds registered level and almost_full outputs.
module fifo_ctrl_16x8
  import fifo_ctrl_16x8_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF
`ifdef FIFO_CTRL_LEVEL_EN
  ,
  parameter int unsigned AF_MARGIN = 2
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_raddr,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef FIFO_CTRL_LEVEL_EN
  ,
  output logic [ADDR_W:0]   level,
  output logic              almost_full
`endif
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  state_t           state;
  logic [CNT_W-1:0] mem_cnt;
  logic [CNT_W-1:0] occ;
  logic [CNT_W-1:0] cnt_nxt;
  logic             push;
  logic             pop;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;

  // Occupancy counts the word parked in the array's read register too.
  assign rd_valid = (state == ST_HEAD);
  assign occ      = mem_cnt + CNT_W'(rd_valid);
  assign wr_ready = (occ < CNT_W'(DEPTH));

  // A push coinciding with flush is accepted by the handshake but dropped.
  assign push      = wr_valid && wr_ready && !flush;
  assign pop       = rd_valid && rd_ready;
  assign mem_re    = (mem_cnt != '0) && (!rd_valid || rd_ready) && !flush;
  assign cnt_nxt   = mem_cnt + CNT_W'(push) - CNT_W'(mem_re);

  assign mem_we    = push;
  assign mem_waddr = wr_ptr;
  assign mem_wdata = wr_data;
  assign mem_raddr = rd_ptr;
  assign rd_data   = mem_rdata;

  fifo_ctrl_16x8_ptr #(.ADDR_W(ADDR_W)) u_wr_ptr (
    .clk (clk),
    .rst (rst),
    .clr (flush),
    .inc (push),
    .ptr (wr_ptr)
  );

  fifo_ctrl_16x8_ptr #(.ADDR_W(ADDR_W)) u_rd_ptr (
    .clk (clk),
    .rst (rst),
    .clr (flush),
    .inc (mem_re),
    .ptr (rd_ptr)
  );

  // Array word count and head-valid FSM; a pop with a refetch keeps HEAD.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_EMPTY;
      mem_cnt <= '0;
    end else if (flush) begin
      state   <= ST_EMPTY;
      mem_cnt <= '0;
    end else begin
      mem_cnt <= cnt_nxt;
      case (state)
        ST_EMPTY: if (mem_re)          state <= ST_HEAD;
        ST_HEAD:  if (pop && !mem_re)  state <= ST_EMPTY;
        default:                       state <= ST_EMPTY;
      endcase
    end
  end

`ifdef FIFO_CTRL_LEVEL_EN
  logic             rd_valid_nxt;
  logic [CNT_W-1:0] occ_nxt;

  assign rd_valid_nxt = mem_re || (rd_valid && !pop);
  assign occ_nxt      = cnt_nxt + CNT_W'(rd_valid_nxt);

  // Registered occupancy tracks the post-edge value of occ.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level       <= '0;
      almost_full <= 1'b0;
    end else if (flush) begin
      level       <= '0;
      almost_full <= 1'b0;
    end else begin
      level       <= occ_nxt;
      almost_full <= (occ_nxt >= CNT_W'(DEPTH - AF_MARGIN));
    end
  end
`endif

endmodule

// File: tb/tb_fifo_ctrl_16x8.sv
// Scoreboard bench for fifo_ctrl_16x8 paired with a behavioural 16x8 array.
module tb_fifo_ctrl_16x8;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic       wr_valid;
  logic       wr_ready;
  logic [7:0] wr_data;
  logic       rd_valid;
  logic       rd_ready;
  logic [7:0] rd_data;
  logic       mem_we;
  logic [3:0] mem_waddr;
  logic [7:0] mem_wdata;
  logic       mem_re;
  logic [3:0] mem_raddr;
  logic [7:0] mem_rdata;
`ifdef FIFO_CTRL_LEVEL_EN
  logic [4:0] level;
  logic       almost_full;
`endif

  always #5 clk = ~clk;

  fifo_ctrl_16x8 dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_data   (wr_data),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .rd_data   (rd_data),
    .mem_we    (mem_we),
    .mem_waddr (mem_waddr),
    .mem_wdata (mem_wdata),
    .mem_re    (mem_re),
    .mem_raddr (mem_raddr),
    .mem_rdata (mem_rdata)
`ifdef FIFO_CTRL_LEVEL_EN
    ,
    .level       (level),
    .almost_full (almost_full)
`endif
  );

  // 16x8 array: synchronous write, registered read.
  logic [7:0] mem [16];
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
    if (mem_re) mem_rdata <= mem[mem_raddr];
  end

  int         errors = 0;
  int         checks = 0;
  logic [7:0] sb [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Inputs change just after the falling edge; outputs are sampled 1ns later.
  task automatic drive(input logic wv, input logic [7:0] wd, input logic rr);
    flush    = 1'b0;
    wr_valid = wv;
    wr_data  = wd;
    rd_ready = rr;
    #1;
  endtask

  task automatic adv();
    if (flush) begin
      sb.delete();
    end else begin
      if (rd_valid && rd_ready) begin
        if (sb.size() == 0) check("pop_unexpected", 32'd1, 32'd0);
        else check("rd_data", 32'(rd_data), 32'(sb.pop_front()));
      end
      if (wr_valid && wr_ready) sb.push_back(wr_data);
    end
    @(negedge clk);
  endtask

  task automatic tick(input logic wv, input logic [7:0] wd, input logic rr);
    drive(wv, wd, rr);
    adv();
  endtask

  task automatic drain();
    for (int i = 0; i < 40; i++) begin
      if (sb.size() == 0 && !rd_valid) break;
      tick(1'b0, 8'h00, 1'b1);
    end
    check("drain_left", 32'(sb.size()), 32'd0);
    check("drain_rd_valid", 32'(rd_valid), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    rst = 1'b1; flush = 1'b0; wr_valid = 1'b0; wr_data = 8'h00; rd_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset state
    drive(1'b0, 8'h00, 1'b0);
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    check("rst_wr_ready", 32'(wr_ready), 32'd1);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_re", 32'(mem_re), 32'd0);
`ifdef FIFO_CTRL_LEVEL_EN
    check("rst_level", 32'(level), 32'd0);
`endif
    adv();

    // First-word latency
    drive(1'b1, 8'hA5, 1'b0);
    check("lat_mem_we", 32'(mem_we), 32'd1);
    check("lat_waddr", 32'(mem_waddr), 32'd0);
    check("lat_wdata", 32'(mem_wdata), 32'hA5);
    check("lat_rv0", 32'(rd_valid), 32'd0);
    adv();
    drive(1'b0, 8'h00, 1'b0);
    check("lat_mem_re", 32'(mem_re), 32'd1);
    check("lat_raddr", 32'(mem_raddr), 32'd0);
    check("lat_rv1", 32'(rd_valid), 32'd0);
    adv();
    drive(1'b0, 8'h00, 1'b0);
    check("lat_rv2", 32'(rd_valid), 32'd1);
    check("lat_rd_data", 32'(rd_data), 32'hA5);
    check("lat_re_idle", 32'(mem_re), 32'd0);
    adv();
    drain();

    // Fill to full, then drain
    for (int i = 0; i < 16; i++) tick(1'b1, 8'(i), 1'b0);
    drive(1'b1, 8'h99, 1'b0);
    check("full_wr_ready", 32'(wr_ready), 32'd0);
    check("full_mem_we", 32'(mem_we), 32'd0);
    check("full_rd_valid", 32'(rd_valid), 32'd1);
    check("full_head", 32'(rd_data), 32'h00);
`ifdef FIFO_CTRL_LEVEL_EN
    check("full_level", 32'(level), 32'd16);
    check("full_af", 32'(almost_full), 32'd1);
`endif
    adv();
    drive(1'b1, 8'h98, 1'b1);
    check("full_pop_wr_ready", 32'(wr_ready), 32'd0);
    adv();
    drive(1'b0, 8'h00, 1'b0);
    check("after_pop_wr_ready", 32'(wr_ready), 32'd1);
    adv();
    drain();

    // Streaming with pointer wrap
    for (int i = 0; i < 40; i++) begin
      drive(1'b1, 8'(64 + i), 1'b1);
      if (i >= 2) check("stream_no_bubble", 32'(rd_valid), 32'd1);
      adv();
    end
    drain();

    // Backpressure holds the head word
    tick(1'b1, 8'h11, 1'b0);
    tick(1'b1, 8'h22, 1'b0);
    tick(1'b1, 8'h33, 1'b0);
    tick(1'b0, 8'h00, 1'b0);
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 8'h00, 1'b0);
      check("bp_rd_valid", 32'(rd_valid), 32'd1);
      check("bp_rd_data", 32'(rd_data), 32'(sb[0]));
      check("bp_mem_re", 32'(mem_re), 32'd0);
      adv();
    end
    drain();

    // Flush with queued words and a pending push
    for (int i = 0; i < 5; i++) tick(1'b1, 8'(80 + i), 1'b0);
    drive(1'b1, 8'h77, 1'b0);
    flush = 1'b1;
    #1;
    check("fl_mem_we", 32'(mem_we), 32'd0);
    check("fl_mem_re", 32'(mem_re), 32'd0);
    adv();
    drive(1'b0, 8'h00, 1'b0);
    check("fl_rd_valid", 32'(rd_valid), 32'd0);
    check("fl_wr_ready", 32'(wr_ready), 32'd1);
    check("fl_mem_re_idle", 32'(mem_re), 32'd0);
`ifdef FIFO_CTRL_LEVEL_EN
    check("fl_level", 32'(level), 32'd0);
`endif
    adv();
    drive(1'b1, 8'h3C, 1'b0);
    check("fl_waddr", 32'(mem_waddr), 32'd0);
    adv();
    drive(1'b0, 8'h00, 1'b0);
    check("fl_mem_re", 32'(mem_re), 32'd1);
    check("fl_raddr", 32'(mem_raddr), 32'd0);
    adv();
    drive(1'b0, 8'h00, 1'b0);
    check("fl_rv", 32'(rd_valid), 32'd1);
    check("fl_rd_data", 32'(rd_data), 32'h3C);
    adv();
    drain();

    // Asynchronous reset mid-cycle with a word at the head
    tick(1'b1, 8'hE1, 1'b0);
    tick(1'b1, 8'hE2, 1'b0);
    tick(1'b0, 8'h00, 1'b0);
    drive(1'b0, 8'h00, 1'b0);
    check("arst_pre_rv", 32'(rd_valid), 32'd1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("arst_rd_valid", 32'(rd_valid), 32'd0);
    check("arst_wr_ready", 32'(wr_ready), 32'd1);
    check("arst_mem_we", 32'(mem_we), 32'd0);
    check("arst_mem_re", 32'(mem_re), 32'd0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    tick(1'b1, 8'h5A, 1'b0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
